// File: rtl/hs_stall_inject.sv
// hs_stall_inject
//   Pass-through valid/ready stage that buffers up to two beats and inserts
//   pseudo-random stall cycles before each beat is offered downstream. It is
//   meant to be dropped between two blocks under test to shake out handshake
//   bugs.
//
//   Handshake rule (both sides): a beat moves on a rising edge where valid and
//   ready are both 1. Once m_valid is 1 it stays 1, and m_data holds its value,
//   until that beat has been taken.
//
//   Ports
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     enable           0 forces the stall probability to zero
//     s_valid/s_ready  upstream handshake, s_data upstream payload (DW bits)
//     m_valid/m_ready  downstream handshake, m_data downstream payload
//     beat_cnt         downstream handshakes taken (wraps)
//     stall_cnt        cycles spent in STALL (wraps)
//     dbg_state        current FSM state (0 EMPTY, 1 STALL, 2 PRESENT)
module hs_stall_inject #(
   parameter int          DW         = 64,
   parameter int          STALL_RATE = 50,
   parameter int          MAX_STALL  = 0,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic [31:0]   beat_cnt,
   output logic [31:0]   stall_cnt,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_STALL   = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   // Stall threshold against a 7-bit random value; 128 means always stall.
   localparam logic [7:0]  THR       = 8'((STALL_RATE * 128) / 100);
   localparam logic [15:0] LFSR_INIT = (SEED == 16'd0) ? 16'd1 : SEED;
   localparam logic [31:0] RUN_CAP   = 32'(MAX_STALL);

   state_t          state_q, state_d;
   logic [1:0]      count_q, count_d;
   logic [DW-1:0]   mem_q [2];
   logic [DW-1:0]   mem_d [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic            m_valid_q, m_valid_d;
   logic [DW-1:0]   m_data_q, m_data_d;
   logic            s_ready_q, s_ready_d;
   logic [31:0]     run_q, run_d;
   logic [31:0]     beat_cnt_q, beat_cnt_d;
   logic [31:0]     stall_cnt_q, stall_cnt_d;
   logic [15:0]     lfsr_q, lfsr_d;

   logic            push, pop, draw;
   logic [7:0]      thr;
   logic [1:0]      after_pop;
   logic [DW-1:0]   next_head;

   always_comb begin
      push        = s_valid & s_ready_q;
      pop         = m_valid_q & m_ready;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
      after_pop   = count_q - {1'b0, pop};
      wr_ptr_d    = wr_ptr_q ^ push;
      rd_ptr_d    = rd_ptr_q ^ pop;
      s_ready_d   = (count_d != 2'd2);
      beat_cnt_d  = beat_cnt_q + {31'd0, pop};
      stall_cnt_d = stall_cnt_q + {31'd0, (state_q == S_STALL)};
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = s_data;
      end

      // Head entry once this cycle's pop has retired; when the FIFO would be
      // empty the only possible new head is the beat being pushed now.
      next_head = (after_pop == 2'd0) ? s_data : mem_q[rd_ptr_q ^ pop];

      thr  = enable ? THR : 8'd0;
      draw = ({1'b0, lfsr_q[6:0]} < thr);
      if ((MAX_STALL > 0) && (run_q == RUN_CAP)) begin
         draw = 1'b0;
      end

      state_d = state_q;
      case (state_q)
         S_EMPTY: begin
            if (push) begin
               state_d = draw ? S_STALL : S_PRESENT;
            end
         end
         S_STALL: begin
            state_d = draw ? S_STALL : S_PRESENT;
         end
         S_PRESENT: begin
            if (pop) begin
               if (count_d != 2'd0) begin
                  state_d = draw ? S_STALL : S_PRESENT;
               end else begin
                  state_d = S_EMPTY;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase

      m_valid_d = (state_d == S_PRESENT);
      m_data_d  = m_data_q;
      if ((state_d == S_PRESENT) && ((state_q != S_PRESENT) || pop)) begin
         m_data_d = next_head;
      end

      // run counts the STALL cycles of the current run including the one about
      // to start, so reaching MAX_STALL ends the run after exactly MAX_STALL
      // cycles.
      run_d = run_q;
      if (state_d == S_PRESENT) begin
         run_d = 32'd0;
      end else if (state_d == S_STALL) begin
         if ((MAX_STALL > 0) && (run_q == RUN_CAP)) begin
            run_d = run_q;
         end else begin
            run_d = run_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         count_q     <= 2'd0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         s_ready_q   <= 1'b0;
         run_q       <= 32'd0;
         beat_cnt_q  <= 32'd0;
         stall_cnt_q <= 32'd0;
         lfsr_q      <= LFSR_INIT;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         mem_q[0]    <= mem_d[0];
         mem_q[1]    <= mem_d[1];
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         s_ready_q   <= s_ready_d;
         run_q       <= run_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         lfsr_q      <= lfsr_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign beat_cnt  = beat_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: doc/hs_stall_inject.md
HS_STALL_INJECT -- requirements
Module: hs_stall_inject

Interface
REQ-001 Parameter DW, default 64: payload width in bits.
REQ-002 Parameter STALL_RATE, default 50: stall probability in percent, legal range 0..100.
REQ-003 Parameter MAX_STALL, default 0: cap on consecutive stall cycles; 0 means uncapped.
REQ-004 Parameter SEED, default 16'hACE1: initial 16-bit LFSR value; a value of 0 SHALL be replaced by 1.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 enable  in  1  when 0, the effective stall rate SHALL be 0.
REQ-008 s_valid  in  1  upstream valid.
REQ-009 s_data  in  DW  upstream payload.
REQ-010 s_ready  out  1  upstream ready.
REQ-011 m_valid  out  1  downstream valid.
REQ-012 m_data  out  DW  downstream payload.
REQ-013 m_ready  in  1  downstream ready.
REQ-014 beat_cnt  out  32  count of downstream handshakes; wraps at 2^32.
REQ-015 stall_cnt  out  32  count of cycles spent in STALL; wraps at 2^32.

Function
REQ-016 A 2-entry FIFO (count 0..2) SHALL buffer payload; push = s_valid & s_ready; pop = m_valid & m_ready.
REQ-017 s_ready SHALL be registered and equal to (count < 2) as of the previous edge; a push and a pop in the same cycle at count 2 SHALL be impossible because s_ready is 0.
REQ-018 The FSM SHALL have states EMPTY, STALL and PRESENT; m_valid SHALL be 1 only in PRESENT.
REQ-019 The FSM SHALL register m_valid and m_data (head entry); the minimum latency from a push to m_valid is 1 cycle.
REQ-020 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle after reset.
REQ-021 draw = (lfsr[6:0] < THR), where THR = (STALL_RATE*128)/100 is computed at elaboration; THR=0 if enable=0; with MAX_STALL>0, draw is forced to 0 when run == MAX_STALL.
REQ-022 Decision point: EMPTY with push, STALL every cycle, or PRESENT with pop and remaining-after-pop count (including a simultaneous push) > 0.
REQ-023 At a decision point, the next state SHALL be STALL if draw=1, else PRESENT.
REQ-024 PRESENT with pop and nothing remaining SHALL go to EMPTY.
REQ-025 PRESENT without pop SHALL hold state; m_valid and m_data SHALL stay stable until pop (AXI valid-stability rule).
REQ-026 run SHALL increment each cycle in STALL, saturate at MAX_STALL, and clear on entry to PRESENT.
REQ-027 The FIFO SHALL preserve order; no beat SHALL be dropped or duplicated.
REQ-028 With STALL_RATE=0 and m_ready=1 held, sustained throughput SHALL be 1 beat per cycle.
REQ-029 With STALL_RATE=100 and MAX_STALL=0, m_valid SHALL never assert; with MAX_STALL=N>0, every beat SHALL be presented after exactly N stall cycles.
REQ-030 beat_cnt SHALL increment on pop; stall_cnt SHALL increment on each STALL cycle.

Reset
REQ-031 rst_n low SHALL immediately force the following, independent of clk: state EMPTY, count 0, m_valid 0, m_data 0, s_ready 0, run 0, beat_cnt 0, stall_cnt 0, lfsr SEED (or 1 if SEED is 0).
REQ-032 s_ready SHALL rise on the first edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard buffered beats; no m_valid pulse SHALL follow the release of reset.

Verification
REQ-034 STALL_RATE=0, m_ready=1, 100 back-to-back beats of incrementing data -> output sequence identical and in order, beat_cnt=100, stall_cnt=0, no bubble after the first beat.
REQ-035 STALL_RATE=100, MAX_STALL=3, 10 beats -> every beat preceded by exactly 3 STALL cycles, stall_cnt=30, beat_cnt=10.
REQ-036 STALL_RATE=50, m_ready toggled randomly, 10k beats -> m_valid never falls and m_data never changes before pop, scoreboard loss-free, stall_cnt/(stall_cnt+beat_cnt) within 0.45..0.55.
REQ-037 m_ready=0 while 3 beats are offered -> s_ready low after 2 pushes, count=2, third beat held upstream; raising m_ready drains all 3 beats in order.
REQ-038 enable=0 with STALL_RATE=100 -> behaves as REQ-034; enable raised mid-stream -> stalling begins at the next decision point.
REQ-039 rst_n pulled low while count=2 in PRESENT -> outputs match REQ-031 immediately; after release, m_valid stays 0 until a new push.
